// File: rtl/wrselh_rmw_if.sv
// Store-request and single-port memory bus for wrselh_rmw.
// The slave modport is the store block's view of the bus. The master modport is the LSU and RAM view.
interface wrselh_rmw_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [1:0]            req_offset;
   logic [1:0]            req_size;
   logic [31:0]           req_data;
   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;
   logic                  done;
   logic                  error;

   modport slave (
      input  req_valid, req_addr, req_offset, req_size, req_data, mem_rdata,
      output req_ready, mem_en, mem_we, mem_addr, mem_wdata, done, error
   );

   modport master (
      output req_valid, req_addr, req_offset, req_size, req_data, mem_rdata,
      input  req_ready, mem_en, mem_we, mem_addr, mem_wdata, done, error
   );
endinterface

// File: rtl/wrselh_rmw.sv
// Places byte, half-word and word stores into the byte lanes of a 32-bit word.
// The RAM has no byte enables, so sub-word stores use a read-modify-write sequence.
module wrselh_rmw #(
   parameter int ADDR_WIDTH   = 10,
   parameter int READ_LATENCY = 1
) (
   input  logic         clk,
   input  logic         rst,
   wrselh_rmw_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WAIT  = 2'd2,
      WRITE = 2'd3
   } state_t;

   localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   state_t                state_r;
   state_t                state_s;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [1:0]            offset_r;
   logic [1:0]            size_r;
   logic [31:0]           data_r;
   logic [CNT_W-1:0]      cnt_r;
   logic [31:0]           wdata_r;
   logic                  en_r;
   logic                  we_r;
   logic                  done_r;
   logic                  error_r;
   logic                  ready_r;
   logic                  accept_s;
   logic                  bad_s;
   logic                  last_wait_s;

   // Reserved size, an odd half-word offset, and a word store with a non-zero offset are rejected.
   function automatic logic is_bad(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = off[0];
         SIZE_WORD: bad = (off != 2'b00);
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Lanes outside the store keep the value read from memory.
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [1:0] off, input logic [1:0] size);
      logic [31:0] w;
      w = old;
      case (size)
         SIZE_BYTE: begin
            case (off)
               2'd0:    w[7:0]   = data[7:0];
               2'd1:    w[15:8]  = data[7:0];
               2'd2:    w[23:16] = data[7:0];
               2'd3:    w[31:24] = data[7:0];
               default: w        = old;
            endcase
         end
         SIZE_HALF: begin
            if (off[1]) begin
               w[31:16] = data[15:0];
            end else begin
               w[15:0] = data[15:0];
            end
         end
         default: w = data;
      endcase
      return w;
   endfunction

   assign accept_s    = bus.req_valid && (state_r == IDLE);
   assign bad_s       = is_bad(bus.req_size, bus.req_offset);
   assign last_wait_s = (state_r == WAIT) && (cnt_r == CNT_LAST);

   // Next-state logic; WAIT lasts exactly READ_LATENCY cycles.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s && !bad_s) begin
               state_s = (bus.req_size == SIZE_WORD) ? WRITE : READ;
            end else begin
               state_s = IDLE;
            end
         end
         READ: state_s = WAIT;
         WAIT: begin
            if (last_wait_s) begin
               state_s = WRITE;
            end else begin
               state_s = WAIT;
            end
         end
         WRITE:   state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register and outputs registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         ready_r <= 1'b1;
         en_r    <= 1'b0;
         we_r    <= 1'b0;
         done_r  <= 1'b0;
         error_r <= 1'b0;
      end else begin
         state_r <= state_s;
         ready_r <= (state_s == IDLE);
         en_r    <= (state_s == READ) || (state_s == WRITE);
         we_r    <= (state_s == WRITE);
         done_r  <= (state_s == WRITE);
         error_r <= accept_s && bad_s;
      end
   end

   // Request capture at accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_r   <= '0;
         offset_r <= 2'b00;
         size_r   <= 2'b00;
         data_r   <= 32'h0000_0000;
      end else if (accept_s) begin
         addr_r   <= bus.req_addr;
         offset_r <= bus.req_offset;
         size_r   <= bus.req_size;
         data_r   <= bus.req_data;
      end
   end

   // Read-latency counter, cleared outside WAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (state_r == WAIT) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= '0;
      end
   end

   // Write word: store data for word stores, merged read data after the last WAIT cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdata_r <= 32'h0000_0000;
      end else if (accept_s && !bad_s && (bus.req_size == SIZE_WORD)) begin
         wdata_r <= bus.req_data;
      end else if (last_wait_s) begin
         wdata_r <= merge(bus.mem_rdata, data_r, offset_r, size_r);
      end
   end

   assign bus.req_ready = ready_r;
   assign bus.mem_en    = en_r;
   assign bus.mem_we    = we_r;
   assign bus.mem_addr  = addr_r;
   assign bus.mem_wdata = wdata_r;
   assign bus.done      = done_r;
   assign bus.error     = error_r;
endmodule

// File: tb/tb_wrselh_rmw.sv
// Scoreboard bench for wrselh_rmw: two instances with read latencies of 1 and 3, each with its own RAM model.
// Expected bus events are queued when a request is driven and checked when they appear.
module tb_wrselh_rmw;
   typedef struct {
      int          kind;   // 0 read, 1 write, 2 error
      logic [9:0]  addr;
      logic [31:0] wdata;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t q1[$];
   exp_t q3[$];

   logic [31:0] mem1 [0:1023];
   logic [31:0] mem3 [0:1023];
   logic [31:0] ref1 [0:1023];
   logic [31:0] ref3 [0:1023];
   logic [31:0] rd1;
   logic [31:0] rd3 [0:2];
   logic        poke1 = 1'b0;
   logic        poke3 = 1'b0;
   logic [9:0]  poke_addr = 10'd0;
   logic [31:0] poke_data = 32'h0;

   wrselh_rmw_if #(.ADDR_WIDTH(10)) b1 ();
   wrselh_rmw_if #(.ADDR_WIDTH(10)) b3 ();

   wrselh_rmw #(.ADDR_WIDTH(10), .READ_LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
   wrselh_rmw #(.ADDR_WIDTH(10), .READ_LATENCY(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM models; read data outside its valid cycle is poisoned.
   always @(posedge clk) begin
      if (poke1) mem1[poke_addr] <= poke_data;
      else if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
      rd1 <= (b1.mem_en && !b1.mem_we) ? mem1[b1.mem_addr] : 32'hBAD0_BAD0;
      if (poke3) mem3[poke_addr] <= poke_data;
      else if (b3.mem_en && b3.mem_we) mem3[b3.mem_addr] <= b3.mem_wdata;
      rd3[0] <= (b3.mem_en && !b3.mem_we) ? mem3[b3.mem_addr] : 32'hBAD0_BAD0;
      rd3[1] <= rd3[0];
      rd3[2] <= rd3[1];
   end
   assign b1.mem_rdata = rd1;
   assign b3.mem_rdata = rd3[2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic rdy(input int sel);
      return (sel == 1) ? b1.req_ready : b3.req_ready;
   endfunction

   task automatic observe(input int sel, input logic en, input logic we, input logic dn,
                          input logic err, input logic ready, input logic [9:0] addr,
                          input logic [31:0] wdata);
      exp_t e;
      int   okind;
      logic have;
      if (!(en || err || dn)) return;
      have = (sel == 1) ? (q1.size() > 0) : (q3.size() > 0);
      if (!have) begin
         chk($sformatf("unexpected_event_dut%0d", sel), {61'd0, en, we, err}, 64'd0);
         return;
      end
      e = (sel == 1) ? q1.pop_front() : q3.pop_front();
      okind = err ? 2 : (en && we) ? 1 : en ? 0 : 3;
      chk($sformatf("kind_dut%0d", sel), 64'(okind), 64'(e.kind));
      chk($sformatf("cycle_dut%0d", sel), 64'(cyc), 64'(e.due));
      if (e.kind == 2) begin
         chk("error_mem_en", {63'd0, en}, 64'd0);
         chk("error_done", {63'd0, dn}, 64'd0);
         chk("error_ready", {63'd0, ready}, 64'd1);
      end else begin
         chk($sformatf("addr_dut%0d", sel), {54'd0, addr}, {54'd0, e.addr});
         chk("busy_ready", {63'd0, ready}, 64'd0);
         chk("done_pulse", {63'd0, dn}, {63'd0, (e.kind == 1)});
         if (e.kind == 1) chk($sformatf("wdata_dut%0d", sel), {32'd0, wdata}, {32'd0, e.wdata});
      end
   endtask

   // Monitor: every bus event must match the head of that instance's queue.
   always @(negedge clk) begin
      observe(1, b1.mem_en, b1.mem_we, b1.done, b1.error, b1.req_ready, b1.mem_addr, b1.mem_wdata);
      observe(3, b3.mem_en, b3.mem_we, b3.done, b3.error, b3.req_ready, b3.mem_addr, b3.mem_wdata);
   end

   task automatic push(input int sel, input int kind, input logic [9:0] addr,
                       input logic [31:0] wdata, input int due);
      exp_t e;
      e.kind = kind; e.addr = addr; e.wdata = wdata; e.due = due;
      if (sel == 1) q1.push_back(e);
      else q3.push_back(e);
   endtask

   task automatic poke(input int sel, input logic [9:0] addr, input logic [31:0] data);
      poke_addr = addr;
      poke_data = data;
      if (sel == 1) begin poke1 = 1'b1; ref1[addr] = data; end
      else begin poke3 = 1'b1; ref3[addr] = data; end
      @(posedge clk); #1;
      poke1 = 1'b0;
      poke3 = 1'b0;
      @(negedge clk);
   endtask

   // Called at a negedge; presents one request and queues its expected bus events.
   task automatic store(input int sel, input logic [9:0] addr, input logic [1:0] off,
                        input logic [1:0] size, input logic [31:0] data);
      int          n;
      int          t;
      int          rl;
      logic        bad;
      logic [31:0] w;
      n = 0;
      while (!rdy(sel) && n < 50) begin @(negedge clk); n++; end
      chk("ready_wait", {63'd0, rdy(sel)}, 64'd1);
      if (!rdy(sel)) return;
      t   = cyc;
      rl  = (sel == 1) ? 1 : 3;
      bad = (size == 2'b11) || (size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00);
      w   = (sel == 1) ? ref1[addr] : ref3[addr];
      if (bad) begin
         push(sel, 2, addr, 32'h0, t + 1);
      end else if (size == 2'b10) begin
         w = data;
         push(sel, 1, addr, w, t + 1);
      end else begin
         if (size == 2'b00) w[8*off +: 8] = data[7:0];
         else if (off[1]) w[31:16] = data[15:0];
         else w[15:0] = data[15:0];
         push(sel, 0, addr, 32'h0, t + 1);
         push(sel, 1, addr, w, t + 2 + rl);
      end
      if (!bad) begin
         if (sel == 1) ref1[addr] = w;
         else ref3[addr] = w;
      end
      if (sel == 1) begin
         b1.req_valid = 1'b1; b1.req_addr = addr; b1.req_offset = off;
         b1.req_size = size; b1.req_data = data;
      end else begin
         b3.req_valid = 1'b1; b3.req_addr = addr; b3.req_offset = off;
         b3.req_size = size; b3.req_data = data;
      end
      @(posedge clk); #1;
      b1.req_valid = 1'b0;
      b3.req_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_quiet(input string tag, input int sel);
      if (sel == 1) chk(tag, {b1.mem_en, b1.mem_we, b1.done, b1.error, b1.mem_addr, b1.mem_wdata}, 64'd0);
      else chk(tag, {b3.mem_en, b3.mem_we, b3.done, b3.error, b3.mem_addr, b3.mem_wdata}, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] saved;
      b1.req_valid = 1'b0; b1.req_addr = 10'd0; b1.req_offset = 2'd0; b1.req_size = 2'd0; b1.req_data = 32'h0;
      b3.req_valid = 1'b0; b3.req_addr = 10'd0; b3.req_offset = 2'd0; b3.req_size = 2'd0; b3.req_data = 32'h0;
      #1;
      check_quiet("reset_outputs_dut1", 1);
      check_quiet("reset_outputs_dut3", 3);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_ready_dut1", {63'd0, b1.req_ready}, 64'd1);
      chk("reset_ready_dut3", {63'd0, b3.req_ready}, 64'd1);

      // Word store: direct write, no read.
      store(1, 10'd5, 2'd0, 2'b10, 32'hDEAD_BEEF);
      // Byte and half-word read-modify-write.
      poke(1, 10'd3, 32'h1122_3344);
      store(1, 10'd3, 2'd2, 2'b00, 32'hFFFF_FFAA);
      poke(1, 10'd3, 32'h1122_3344);
      store(1, 10'd3, 2'd2, 2'b01, 32'h1234_5678);
      store(1, 10'd3, 2'd0, 2'b01, 32'hCAFE_0BAD);
      // Longer read latency.
      poke(3, 10'd3, 32'h1122_3344);
      store(3, 10'd3, 2'd2, 2'b01, 32'h1234_5678);
      // Rejected requests, including back-to-back.
      store(1, 10'd3, 2'd1, 2'b01, 32'h0000_1111);
      store(1, 10'd3, 2'd0, 2'b11, 32'h0000_2222);
      store(1, 10'd4, 2'd2, 2'b10, 32'h0000_3333);
      store(3, 10'd3, 2'd3, 2'b01, 32'h0000_4444);
      // Back-to-back byte stores into one word.
      poke(1, 10'd7, 32'h0000_0000);
      for (int i = 0; i < 4; i++) begin
         store(1, 10'd7, 2'(i), 2'b00, 32'hA0 + 32'(i));
      end
      repeat (6) @(negedge clk);
      chk("byte_lanes_word", {32'd0, mem1[7]}, 64'hA3A2_A1A0);

      // Reset during WAIT aborts the sequence without a write.
      poke(3, 10'd9, 32'h5566_7788);
      saved = ref3[9];
      store(3, 10'd9, 2'd1, 2'b00, 32'h0000_00FF);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check_quiet("reset_abort_outputs", 3);
      q3.delete();
      ref3[9] = saved;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ready", {63'd0, b3.req_ready}, 64'd1);
      repeat (6) @(negedge clk);
      chk("abort_no_write", {32'd0, mem3[9]}, {32'd0, saved});
      store(3, 10'd9, 2'd3, 2'b00, 32'h0000_00EE);
      store(3, 10'd9, 2'd0, 2'b10, 32'h0BAD_F00D);

      repeat (10) @(negedge clk);
      chk("drain_q1", 64'(q1.size()), 64'd0);
      chk("drain_q3", 64'(q3.size()), 64'd0);
      chk("final_word_dut1", {32'd0, mem1[3]}, {32'd0, ref1[3]});
      chk("final_word_dut3", {32'd0, mem3[9]}, 64'h0BAD_F00D);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
